// File: rtl/soc_vga_pkg.sv
// Shared VGA framebuffer types and default frame geometry for the fill engine and scan-out.
`default_nettype none

package soc_vga_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  localparam int DEFAULT_FRAME_WIDTH  = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;

endpackage

`default_nettype wire

// File: rtl/soc_vga_fill_clip.sv
// soc_vga_fill_clip: combinational clip of a fill rectangle against the frame.
`default_nettype none

module soc_vga_fill_clip
  import soc_vga_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT
) (
  input  logic [11:0] i_rect_x,
  input  logic [11:0] i_rect_y,
  input  logic [11:0] i_rect_w,
  input  logic [11:0] i_rect_h,
  output logic [12:0] o_x_end,
  output logic [12:0] o_y_end,
  output logic        o_empty
);

  localparam logic [12:0] c_FW = 13'(FRAME_WIDTH);
  localparam logic [12:0] c_FH = 13'(FRAME_HEIGHT);

  logic [12:0] w_x_sum;
  logic [12:0] w_y_sum;

  // One extra bit so that a maximal origin plus a maximal size cannot wrap.
  always_comb begin
    w_x_sum = {1'b0, i_rect_x} + {1'b0, i_rect_w};
    w_y_sum = {1'b0, i_rect_y} + {1'b0, i_rect_h};
    o_x_end = (w_x_sum > c_FW) ? c_FW : w_x_sum;
    o_y_end = (w_y_sum > c_FH) ? c_FH : w_y_sum;
    o_empty = (i_rect_w == 12'd0) || (i_rect_h == 12'd0) ||
              ({1'b0, i_rect_x} >= c_FW) || ({1'b0, i_rect_y} >= c_FH);
  end

endmodule

`default_nettype wire

// File: rtl/soc_vga_fill.sv
// soc_vga_fill: rectangle-fill engine writing the RGB332 framebuffer, one pixel per handshake.
// Optional checkerboard colour input enabled by SOC_VGA_FILL_PATTERN_EN.
`default_nettype none

module soc_vga_fill
  import soc_vga_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  start,
  input  logic [11:0]           rect_x,
  input  logic [11:0]           rect_y,
  input  logic [11:0]           rect_w,
  input  logic [11:0]           rect_h,
  input  logic [7:0]            color,
`ifdef SOC_VGA_FILL_PATTERN_EN
  input  logic [7:0]            color_alt,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  fb_wr_en,
  output logic [ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [7:0]            fb_wr_data,
  input  logic                  fb_wr_ready
);

  localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
  localparam logic [1:0] c_ST_SETUP = ST_SETUP;
  localparam logic [1:0] c_ST_FILL  = ST_FILL;
  localparam logic [1:0] c_ST_DONE  = ST_DONE;
  localparam logic [ADDR_WIDTH-1:0] c_FW = ADDR_WIDTH'(FRAME_WIDTH);

  logic [1:0]            r_state;
  logic [11:0]           r_rect_x, r_rect_y, r_rect_w, r_rect_h;
  logic [11:0]           r_x, r_y;
  pixel_t                r_color;
`ifdef SOC_VGA_FILL_PATTERN_EN
  pixel_t                r_color_alt;
`endif
  logic [ADDR_WIDTH-1:0] r_row_base, r_addr;
  pixel_t                r_data;
  logic                  r_busy, r_done, r_wr_en;

  logic [12:0]           w_x_end, w_y_end;
  logic                  w_empty, w_last_col, w_last_row;
  logic [11:0]           w_nx, w_ny;
  logic [ADDR_WIDTH-1:0] w_nrow, w_naddr;
  pixel_t                w_npix;

  soc_vga_fill_clip #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) u_clip (
    .i_rect_x (r_rect_x),
    .i_rect_y (r_rect_y),
    .i_rect_w (r_rect_w),
    .i_rect_h (r_rect_h),
    .o_x_end  (w_x_end),
    .o_y_end  (w_y_end),
    .o_empty  (w_empty)
  );

  // Next pixel to present: the rectangle origin from SETUP, otherwise the successor of the current one.
  always_comb begin
    w_last_col = (({1'b0, r_x} + 13'd1) == w_x_end);
    w_last_row = (({1'b0, r_y} + 13'd1) == w_y_end);
    if (r_state == c_ST_SETUP) begin
      w_nx    = r_rect_x;
      w_ny    = r_rect_y;
      w_nrow  = ADDR_WIDTH'(r_rect_y) * c_FW;
      w_naddr = w_nrow + ADDR_WIDTH'(r_rect_x);
    end else if (w_last_col) begin
      w_nx    = r_rect_x;
      w_ny    = r_y + 12'd1;
      w_nrow  = r_row_base + c_FW;
      w_naddr = w_nrow + ADDR_WIDTH'(r_rect_x);
    end else begin
      w_nx    = r_x + 12'd1;
      w_ny    = r_y;
      w_nrow  = r_row_base;
      w_naddr = r_addr + ADDR_WIDTH'(1);
    end
`ifdef SOC_VGA_FILL_PATTERN_EN
    w_npix = (w_nx[0] ^ w_ny[0]) ? r_color_alt : r_color;
`else
    w_npix = r_color;
`endif
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state    <= c_ST_IDLE;
      r_rect_x   <= '0;
      r_rect_y   <= '0;
      r_rect_w   <= '0;
      r_rect_h   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_color    <= '0;
`ifdef SOC_VGA_FILL_PATTERN_EN
      r_color_alt <= '0;
`endif
      r_row_base <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_rect_x <= rect_x;
            r_rect_y <= rect_y;
            r_rect_w <= rect_w;
            r_rect_h <= rect_h;
            r_color  <= color;
`ifdef SOC_VGA_FILL_PATTERN_EN
            r_color_alt <= color_alt;
`endif
            r_busy   <= 1'b1;
            r_state  <= c_ST_SETUP;
          end
        end
        c_ST_SETUP: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= c_ST_DONE;
          end else begin
            r_wr_en    <= 1'b1;
            r_x        <= w_nx;
            r_y        <= w_ny;
            r_row_base <= w_nrow;
            r_addr     <= w_naddr;
            r_data     <= w_npix;
            r_state    <= c_ST_FILL;
          end
        end
        c_ST_FILL: begin
          if (fb_wr_ready) begin
            if (w_last_col && w_last_row) begin
              r_wr_en <= 1'b0;
              r_done  <= 1'b1;
              r_state <= c_ST_DONE;
            end else begin
              r_x        <= w_nx;
              r_y        <= w_ny;
              r_row_base <= w_nrow;
              r_addr     <= w_naddr;
              r_data     <= w_npix;
            end
          end
        end
        c_ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign fb_wr_en   = r_wr_en;
  assign fb_wr_addr = r_addr;
  assign fb_wr_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_soc_vga_fill.sv
// tb_soc_vga_fill: directed fills checked against a nested-loop framebuffer model.
`default_nettype none

module tb_soc_vga_fill;

  localparam int FW = 640;
  localparam int FH = 480;
`ifdef SOC_VGA_FILL_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] rect_x = '0, rect_y = '0, rect_w = '0, rect_h = '0;
  logic [7:0]  color = '0;
`ifdef SOC_VGA_FILL_PATTERN_EN
  logic [7:0]  color_alt = '0;
`endif
  logic        busy, done, fb_wr_en;
  logic [31:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic        fb_wr_ready = 1'b1;

  soc_vga_fill dut (
    .clk         (clk),
    .res_n       (res_n),
    .start       (start),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .color       (color),
`ifdef SOC_VGA_FILL_PATTERN_EN
    .color_alt   (color_alt),
`endif
    .busy        (busy),
    .done        (done),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .fb_wr_ready (fb_wr_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected write stream and observed writes
  int exp_addr[$];
  int exp_data[$];
  int got_addr[$];
  int got_data[$];

  int busy_cnt, done_cnt, done_cyc, first_en_cyc, stall_cnt, xfer_cnt;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_data;

  function automatic void build_model(input int x, input int y, input int w, input int h,
                                      input int c, input int alt);
    int xe, ye;
    exp_addr.delete();
    exp_data.delete();
    xe = (x + w < FW) ? x + w : FW;
    ye = (y + h < FH) ? y + h : FH;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++) begin
        exp_addr.push_back(yy * FW + xx);
        exp_data.push_back((PAT && ((xx + yy) % 2 == 1)) ? alt : c);
      end
  endfunction

  // Single compare process: every transfer must be the next pixel of the model stream.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fb_wr_en && first_en_cyc < 0) first_en_cyc = cyc;
    if (prev_stall && fb_wr_en) begin
      chk("stall_addr_hold", fb_wr_addr, prev_addr);
      chk("stall_data_hold", fb_wr_data, prev_data);
    end
    prev_stall = fb_wr_en && !fb_wr_ready;
    prev_addr  = fb_wr_addr;
    prev_data  = fb_wr_data;
    if (fb_wr_en && !fb_wr_ready) stall_cnt++;
    if (fb_wr_en && fb_wr_ready) begin
      xfer_cnt++;
      got_addr.push_back(int'(fb_wr_addr));
      got_data.push_back(int'(fb_wr_data));
      if (exp_addr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", fb_wr_addr, fb_wr_data);
      end else begin
        chk("wr_addr", fb_wr_addr, exp_addr.pop_front());
        chk("wr_data", fb_wr_data, exp_data.pop_front());
      end
    end
  end

  task automatic run_fill(input int x, input int y, input int w, input int h,
                          input logic [7:0] c, input logic [7:0] alt,
                          input bit toggle, input int extra_off, input int abort_off);
    int npix, t0;
    bit finished;
    build_model(x, y, w, h, c, alt);
    npix = exp_addr.size();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_en_cyc = -1;
    stall_cnt = 0; xfer_cnt = 0;
    got_addr.delete();
    got_data.delete();
    finished = 1'b0;
    @(posedge clk); #1;
    rect_x = 12'(x); rect_y = 12'(y); rect_w = 12'(w); rect_h = 12'(h);
    color = c;
`ifdef SOC_VGA_FILL_PATTERN_EN
    color_alt = alt;
`endif
    fb_wr_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    for (int k = 1; k < 1000; k++) begin
      @(posedge clk); #1;
      start = (k == extra_off);
      if (start) begin
        rect_x = 12'd0; rect_y = 12'd0; rect_w = 12'd50; rect_h = 12'd50; color = 8'h55;
      end
      fb_wr_ready = toggle ? !(k == 3 || k == 4) : 1'b1;
      res_n = (k == abort_off) ? 1'b0 : 1'b1;
      if (abort_off > 0 && k == abort_off + 1) begin
        chk("abort_wr_en_low", fb_wr_en, 1'b0);
        chk("abort_busy_low", busy, 1'b0);
        chk("abort_xfers", xfer_cnt, 3);
        finished = 1'b1;
        break;
      end
      if (done_cnt > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    fb_wr_ready = 1'b1;
    res_n = 1'b1;
    chk("fill_terminated", finished, 1'b1);
    if (abort_off > 0) begin
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      exp_addr.delete();
      exp_data.delete();
    end else begin
      chk("done_pulses", done_cnt, 1);
      chk("busy_cycles", busy_cnt, npix + 2 + stall_cnt);
      chk("done_cycle", done_cyc, t0 + 2 + npix + stall_cnt);
      chk("all_pixels_written", exp_addr.size(), 0);
      chk("xfer_count", xfer_cnt, npix);
      chk("first_en_cycle", first_en_cyc, (npix > 0) ? t0 + 2 : -1);
      chk("idle_wr_en", fb_wr_en, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit1[6];
    lit1 = '{3210, 3211, 3212, 3850, 3851, 3852};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_en", fb_wr_en, 1'b0);
    chk("rst_addr", fb_wr_addr, 32'd0);
    chk("rst_data", fb_wr_data, 8'd0);
    res_n = 1'b1;

    // Basic 3x2 fill
    run_fill(10, 5, 3, 2, 8'hE0, 8'hE0, 1'b0, -1, -1);
    chk("t1_count", got_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_addr.size()) begin
        chk("t1_lit_addr", got_addr[i], lit1[i]);
        chk("t1_lit_data", got_data[i], 8'hE0);
      end
    end

    // Right/bottom clipping
    run_fill(638, 479, 5, 5, 8'h1F, 8'h1F, 1'b0, -1, -1);
    chk("t2_count", got_addr.size(), 2);
    if (got_addr.size() == 2) begin
      chk("t2_lit_addr0", got_addr[0], 307198);
      chk("t2_lit_addr1", got_addr[1], 307199);
    end

    // Empty fills
    run_fill(100, 100, 0, 4, 8'hFF, 8'hFF, 1'b0, -1, -1);
    run_fill(700, 10, 3, 3, 8'hFF, 8'hFF, 1'b0, -1, -1);
    run_fill(5, 480, 2, 2, 8'hFF, 8'hFF, 1'b0, -1, -1);
    chk("t3_no_writes", got_addr.size(), 0);

    // Backpressure: ready 1,0,0,1 on a 2x1 fill
    run_fill(50, 60, 2, 1, 8'h1F, 8'hAA, 1'b1, -1, -1);
    chk("t4_stalls", stall_cnt, 2);
    chk("t4_xfers", got_addr.size(), 2);

    // Backpressure across a row boundary
    run_fill(639, 10, 4, 3, 8'h33, 8'hCC, 1'b1, -1, -1);

    // Start while busy ignored, then mid-fill reset, then recovery
    run_fill(200, 100, 4, 3, 8'h42, 8'h24, 1'b0, 4, -1);
    run_fill(20, 30, 4, 2, 8'h77, 8'h88, 1'b0, -1, 4);
    run_fill(1, 1, 1, 1, 8'h99, 8'h66, 1'b0, -1, -1);

    // Saturating clip arithmetic: 40x10 pixels survive
    run_fill(600, 470, 4095, 4095, 8'h12, 8'h21, 1'b0, -1, -1);
    chk("t_sat_count", got_addr.size(), 400);

    // Pattern fill at the origin
    run_fill(0, 0, 2, 2, 8'h03, 8'h1C, 1'b0, -1, -1);
    chk("t6_count", got_addr.size(), 4);
    if (got_addr.size() == 4) begin
      chk("t6_lit_addr2", got_addr[2], 640);
      chk("t6_lit_addr3", got_addr[3], 641);
      chk("t6_lit_data0", got_data[0], 8'h03);
      chk("t6_lit_data1", got_data[1], PAT ? 8'h1C : 8'h03);
      chk("t6_lit_data2", got_data[2], PAT ? 8'h1C : 8'h03);
      chk("t6_lit_data3", got_data[3], 8'h03);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/soc_vga_fill.md
Name: soc_vga_fill

Overview:
Hardware rectangle-fill engine, the write-side counterpart of the VGA scan-out controller. The scan-out controller reads the 8-bit RGB332 framebuffer linearly (address = y*FRAME_WIDTH + x). This block writes that same framebuffer.
- CPU-facing registers supply rectangle origin, size and colour, then pulse start.
- The engine clips the rectangle to the frame and streams one pixel write per accepted handshake into the framebuffer write port.

Parameters:
FRAME_WIDTH, 640, active pixels per line; row stride of the framebuffer.
FRAME_HEIGHT, 480, active lines per frame.
ADDR_WIDTH, 32, framebuffer address width.

Ports:
clk  in  1  system clock.
res_n  in  1  reset, synchronous, active-low.
start  in  1  one-cycle request to begin a fill; sampled only in IDLE.
rect_x  in  12  left column of rectangle.
rect_y  in  12  top line of rectangle.
rect_w  in  12  width in pixels.
rect_h  in  12  height in lines.
color  in  8  RGB332 fill colour.
busy  out  1  high from the cycle after an accepted start through the DONE cycle.
done  out  1  one-cycle pulse when a fill completes, including empty fills.
fb_wr_en  out  1  write request valid.
fb_wr_addr  out  ADDR_WIDTH  framebuffer pixel address.
fb_wr_data  out  8  pixel value.
fb_wr_ready  in  1  framebuffer accepts the write this cycle.

Behaviour:
- Clock and reset: one clock `clk`. Reset `res_n` is synchronous and active-low.
- Reset values: busy=0, done=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, FSM=IDLE.
- Reset mid-fill: the engine aborts. The next cycle has fb_wr_en=0, with no done pulse.
- Register capture: rect_*, color and the optional colour input are captured on an accepted start. Later input changes do not affect a fill in progress.

FSM states and transitions:
- IDLE: start=1 -> SETUP. start while busy is ignored and is not queued.
- SETUP (1 cycle): clip the rectangle.
  - x_end = min(rect_x+rect_w, FRAME_WIDTH); y_end = min(rect_y+rect_h, FRAME_HEIGHT).
  - Clipping arithmetic is 13-bit so 4095+4095 does not wrap.
  - Row base = rect_y*FRAME_WIDTH (registered).
  - Empty fill: if rect_w==0, rect_h==0, rect_x>=FRAME_WIDTH or rect_y>=FRAME_HEIGHT -> DONE, with no writes.
  - Otherwise -> FILL, with fb_wr_addr = row base + rect_x and fb_wr_en=1.
- FILL: fb_wr_en=1 continuously.
  - fb_wr_addr and fb_wr_data hold stable until fb_wr_ready=1; a transfer occurs on fb_wr_en & fb_wr_ready.
  - After a transfer, x advances and address+1.
  - At x==x_end-1 the engine moves to the next row: address = row base + FRAME_WIDTH + rect_x, with no bubble cycle.
  - After the transfer of the last pixel (x_end-1, y_end-1) -> DONE, and fb_wr_en drops the next cycle.
- DONE (1 cycle): done=1, busy=1 -> IDLE.
- Throughput and latency:
  - First fb_wr_en is 2 cycles after start.
  - With fb_wr_ready tied high, one pixel per cycle.
  - Total busy cycles = pixels + 2.

Optional Feature:
SOC_VGA_FILL_PATTERN_EN:
- Defined: adds input color_alt[7:0], captured at start. Pixels where (x+y)[0]==1 use color_alt, others use color, giving a checkerboard in absolute frame coordinates.
- Undefined: the port is absent and every pixel uses color.

Decomposition:
- Package soc_vga_pkg holds:
  - pixel_t (8-bit RGB332) and fill_state_t enum (IDLE, SETUP, FILL, DONE).
  - Default FRAME_WIDTH/FRAME_HEIGHT constants, shared with the scan-out controller.
- One natural sub-module: soc_vga_fill_clip, combinational. It produces x_end, y_end and the empty flag from rect_* and the frame size.

Test Plan:
1. Basic 3x2 fill: rect (10,5,3,2), color 8'hE0, ready=1 -> writes to 3210,3211,3212,3850,3851,3852 (all data E0) on consecutive cycles, then one done pulse.
2. Right/bottom clipping: rect (638,479,5,5) -> exactly two writes, 307198 and 307199.
3. Empty cases: w=0, and separately x=700 -> no fb_wr_en, done 2 cycles after start, busy high exactly 2 cycles.
4. Backpressure: fb_wr_ready toggled 1,0,0,1 during a 2x1 fill -> addr/data stable while stalled, exactly 2 transfers, none duplicated or skipped.
5. Start while busy plus mid-fill reset: second start during FILL is ignored. res_n=0 after 3 transfers -> fb_wr_en=0 the next cycle, no done, new fill works afterwards.
6. PATTERN_EN: rect (0,0,2,2), color 8'h03, color_alt 8'h1C -> data 03,1C at addresses 0,1; 1C,03 at 640,641.
